// File: rtl/prio_encoder_hs.sv
// ---------------------------------------------------------------------------
// prio_encoder_hs
//   Registered N-to-ENC_W priority encoder with valid/ready on both sides.
//   Converts a request vector into the index of a granted bit. Zero vectors
//   and multi-hot vectors are flagged. Optional round-robin start pointer
//   (MODE=1) and optional drain mode (DRAIN=1) that emits one beat per set bit.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. A producer holds its payload stable while
//   valid is high and ready is low. in_ready never looks at in_valid.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_req     in   N      request vector
//   in_valid   in   1      in_req valid
//   in_ready   out  1      block can accept in_req this cycle
//   out_code   out  ENC_W  index of granted bit (0 for an all-zero vector)
//   out_valid  out  1      out_* valid
//   out_ready  in   1      downstream accepts out_* this cycle
//   out_none   out  1      accepted vector was all-zero
//   out_multi  out  1      accepted vector had more than one bit set
//   out_last   out  1      final beat for the current vector
//   dbg_state  out  1      FSM state for observation (1 = draining)
// ---------------------------------------------------------------------------
module prio_encoder_hs #(
    parameter int N     = 8,
    parameter int ENC_W = $clog2(N),
    parameter int MODE  = 0,
    parameter int DRAIN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_req,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ENC_W-1:0] out_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_none,
    output logic             out_multi,
    output logic             out_last,
    output logic             dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_valid;
    logic [ENC_W-1:0] r_code;
    logic             r_none;
    logic             r_multi;
    logic             r_last;
    logic [N-1:0]     r_rem;
    logic [ENC_W-1:0] r_ptr;

    logic             w_slot_free;
    logic             w_accept;
    logic             w_load;
    logic [N-1:0]     w_src;
    logic             w_src_zero;
    logic [ENC_W-1:0] w_start;
    logic [ENC_W-1:0] w_pick;
    logic [N-1:0]     w_rem_nxt;
    logic             w_multi_in;

    // First set bit of v scanning start, start+1, ..., N-1, 0, ..., start-1.
    // The wrap is at N, so non power-of-2 widths never produce a code >= N.
    function automatic logic [ENC_W-1:0] pick_first(input logic [N-1:0]     v,
                                                    input logic [ENC_W-1:0] start);
        logic             found;
        logic [ENC_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!found && v[j]) begin
                found = 1'b1;
                idx   = ENC_W'(j);
            end
        end
        return idx;
    endfunction

    assign w_slot_free = !r_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_load      = w_accept || ((r_state == S_DRAIN) && w_slot_free);

    // While draining, the pick source is the leftover vector, otherwise the input.
    assign w_src      = (r_state == S_DRAIN) ? r_rem : in_req;
    assign w_src_zero = (w_src == '0);
    assign w_start    = (MODE != 0) ? r_ptr : '0;
    assign w_pick     = pick_first(w_src, w_start);
    assign w_rem_nxt  = w_src & ~(N'(1) << w_pick);
    // x & (x-1) clears the lowest set bit; non-zero means two or more bits set.
    assign w_multi_in = ((in_req & (in_req - N'(1))) != '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_src_zero && (DRAIN != 0) && (w_rem_nxt != '0))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_slot_free && (w_rem_nxt == '0))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == S_IDLE) && w_slot_free;
        dbg_state = (r_state == S_DRAIN);
    end

    // ---------------- output register, leftover vector, pointer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_none  <= 1'b0;
            r_multi <= 1'b0;
            r_last  <= 1'b0;
            r_rem   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_code  <= w_src_zero ? '0 : w_pick;
            r_none  <= w_src_zero;
            // A drain is only ever entered for a multi-hot vector.
            r_multi <= (r_state == S_DRAIN) ? 1'b1 : w_multi_in;
            // Without drain, extra bits are dropped and every beat is last.
            r_last  <= (DRAIN == 0) || (w_rem_nxt == '0);
            r_rem   <= (DRAIN != 0) ? w_rem_nxt : '0;
            if ((MODE != 0) && !w_src_zero)
                r_ptr <= ((int'(w_pick) + 1) == N) ? '0 : w_pick + 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign out_none  = r_none;
    assign out_multi = r_multi;
    assign out_last  = r_last;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// ---------------------------------------------------------------------------
// tb_prio_encoder_hs
//   Four DUT configurations share one clock and reset:
//     inst 0: N=8 MODE=0 DRAIN=0   inst 1: N=8 MODE=0 DRAIN=1
//     inst 2: N=8 MODE=1 DRAIN=0   inst 3: N=5 MODE=1 DRAIN=1
//   The reference model turns each accepted vector into its list of beats:
//   the set bits in circular order from the start index, one beat (or all
//   beats when draining), and moves the round-robin pointer past the last one.
// ---------------------------------------------------------------------------
module tb_prio_encoder_hs;

  localparam int NI = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NI-1:0][7:0]   req;
  logic [NI-1:0]        vin;
  logic [NI-1:0]        rdy;
  logic [NI-1:0][2:0]   code;
  logic [NI-1:0]        ov;
  logic [NI-1:0]        ordy;
  logic [NI-1:0]        onone;
  logic [NI-1:0]        omulti;
  logic [NI-1:0]        olast;
  logic [NI-1:0]        dbg;

  always #5 clk = ~clk;

  prio_encoder_hs #(.N(8), .MODE(0), .DRAIN(0)) u0 (
    .clk(clk), .rst(rst), .in_req(req[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
    .out_code(code[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_none(onone[0]),
    .out_multi(omulti[0]), .out_last(olast[0]), .dbg_state(dbg[0]));
  prio_encoder_hs #(.N(8), .MODE(0), .DRAIN(1)) u1 (
    .clk(clk), .rst(rst), .in_req(req[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
    .out_code(code[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_none(onone[1]),
    .out_multi(omulti[1]), .out_last(olast[1]), .dbg_state(dbg[1]));
  prio_encoder_hs #(.N(8), .MODE(1), .DRAIN(0)) u2 (
    .clk(clk), .rst(rst), .in_req(req[2]), .in_valid(vin[2]), .in_ready(rdy[2]),
    .out_code(code[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_none(onone[2]),
    .out_multi(omulti[2]), .out_last(olast[2]), .dbg_state(dbg[2]));
  prio_encoder_hs #(.N(5), .MODE(1), .DRAIN(1)) u3 (
    .clk(clk), .rst(rst), .in_req(req[3][4:0]), .in_valid(vin[3]), .in_ready(rdy[3]),
    .out_code(code[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_none(onone[3]),
    .out_multi(omulti[3]), .out_last(olast[3]), .dbg_state(dbg[3]));

  // ---------------- scoreboard state ----------------
  // beat packing: {code[2:0], none, multi, last}
  logic [5:0] exp_q[NI][$];
  logic [5:0] got_q[NI][$];
  int         ptr_m[NI];
  logic       acc[NI];
  logic       stalled[NI];
  logic [5:0] prev_beat[NI];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic int n_of(int k);     return (k == 3) ? 5 : 8;           endfunction
  function automatic bit mode_of(int k);  return (k >= 2);                   endfunction
  function automatic bit drain_of(int k); return (k == 1) || (k == 3);       endfunction

  function automatic logic [5:0] beat_of(int k);
    return {code[k], onone[k], omulti[k], olast[k]};
  endfunction

  task automatic check(input string name, input int k, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=0x%0h expected=0x%0h at %0t", name, k, got, exp, $time);
    end
  endtask

  // Reference model: expected beats for one accepted vector.
  task automatic model_accept(input int k, input logic [7:0] v_raw);
    int         n;
    logic [7:0] v;
    int         cnt;
    int         total;
    int         emitted;
    int         start;
    int         last_idx;
    logic [2:0] c;
    n = n_of(k);
    v = v_raw & 8'((1 << n) - 1);
    cnt = $countones(v);
    if (cnt == 0) begin
      exp_q[k].push_back({3'd0, 1'b1, 1'b0, 1'b1});
      return;
    end
    total    = drain_of(k) ? cnt : 1;
    start    = mode_of(k) ? ptr_m[k] : 0;
    emitted  = 0;
    last_idx = 0;
    for (int i = 0; i < n; i++) begin
      int j;
      j = (start + i) % n;
      if (v[j] && emitted < total) begin
        emitted++;
        c = 3'(j);
        exp_q[k].push_back({c, 1'b0, (cnt > 1), (emitted == total)});
        last_idx = j;
      end
    end
    if (mode_of(k)) ptr_m[k] = (last_idx + 1) % n;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NI; k++) begin
      exp_q[k].delete();
      got_q[k].delete();
      ptr_m[k]   = 0;
      stalled[k] = 1'b0;
      acc[k]     = 1'b0;
    end
  endtask

  // One clock cycle. Called at a falling edge with inputs already driven.
  task automatic step();
    #1;
    for (int k = 0; k < NI; k++) begin
      int sz;
      sz = exp_q[k].size();
      check("out_valid", k, ov[k], (sz > 0));
      check("in_ready", k, rdy[k], (sz == 0) || (sz == 1 && ordy[k]));
      check("drain_state", k, dbg[k], (sz > 1));
      if (stalled[k]) check("stall_hold", k, beat_of(k), prev_beat[k]);
      if (ov[k] && ordy[k]) begin
        got_q[k].push_back(beat_of(k));
        if (sz > 0) check("beat", k, beat_of(k), exp_q[k].pop_front());
        if (k == 3) check("code_range", k, (code[k] < 3'd5), 1);
      end
      stalled[k]   = ov[k] && !ordy[k];
      prev_beat[k] = beat_of(k);
      acc[k]       = vin[k] && rdy[k];
      if (acc[k]) model_accept(k, req[k]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int k, input logic [7:0] v);
    bit done;
    done   = 1'b0;
    req[k] = v;
    vin[k] = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      step();
      done = acc[k];
    end
    vin[k] = 1'b0;
    check("send_timeout", k, done, 1);
  endtask

  task automatic collect(input int k, input int m);
    for (int t = 0; t < 60 && got_q[k].size() < m; t++) step();
    check("collect_timeout", k, (got_q[k].size() >= m), 1);
  endtask

  task automatic expect_beat(input string name, input int k, input logic [2:0] c,
                             input logic none, input logic multi, input logic last);
    logic [5:0] b;
    b = 6'h3f;
    if (got_q[k].size() > 0) b = got_q[k].pop_front();
    check(name, k, b, {c, none, multi, last});
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    vin  = '0;
    ordy = '1;
    req  = '0;
    clear_model();
    @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_valid", k, ov[k], 0);
      check("rst_beat", k, beat_of(k), 0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] req;
    logic [2:0] code;
    logic       none;
    logic       multi;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [2:0] frozen_code;
    tbl[0]  = '{8'h01, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h02, 3'd1, 1'b0, 1'b0};
    tbl[2]  = '{8'h04, 3'd2, 1'b0, 1'b0};
    tbl[3]  = '{8'h08, 3'd3, 1'b0, 1'b0};
    tbl[4]  = '{8'h10, 3'd4, 1'b0, 1'b0};
    tbl[5]  = '{8'h20, 3'd5, 1'b0, 1'b0};
    tbl[6]  = '{8'h40, 3'd6, 1'b0, 1'b0};
    tbl[7]  = '{8'h80, 3'd7, 1'b0, 1'b0};
    tbl[8]  = '{8'h00, 3'd0, 1'b1, 1'b0};
    tbl[9]  = '{8'hFF, 3'd0, 1'b0, 1'b1};
    tbl[10] = '{8'h68, 3'd3, 1'b0, 1'b1};
    tbl[11] = '{8'hC0, 3'd6, 1'b0, 1'b1};

    do_reset();

    // fixed priority, single beat per vector (legacy one-hot map included)
    for (int i = 0; i < 12; i++) begin
      send(0, tbl[i].req);
      collect(0, 1);
      expect_beat("table", 0, tbl[i].code, tbl[i].none, tbl[i].multi, 1'b1);
    end

    // drain: 1001_0010 -> 1, 4, 7; in_ready low until the last beat goes
    send(1, 8'b1001_0010);
    #1;
    check("drain_ready_low", 1, rdy[1], 0);
    collect(1, 3);
    expect_beat("drain_b0", 1, 3'd1, 1'b0, 1'b1, 1'b0);
    expect_beat("drain_b1", 1, 3'd4, 1'b0, 1'b1, 1'b0);
    expect_beat("drain_b2", 1, 3'd7, 1'b0, 1'b1, 1'b1);
    check("drain_ready_back", 1, rdy[1], 1);

    // back-pressure mid-drain: outputs frozen, no loss
    send(1, 8'b0101_0110);
    ordy[1] = 1'b0;
    repeat (5) step();
    frozen_code = code[1];
    check("bp_code", 1, frozen_code, 1);
    check("bp_last", 1, olast[1], 0);
    ordy[1] = 1'b1;
    collect(1, 4);
    expect_beat("bp_b0", 1, 3'd1, 1'b0, 1'b1, 1'b0);
    expect_beat("bp_b1", 1, 3'd2, 1'b0, 1'b1, 1'b0);
    expect_beat("bp_b2", 1, 3'd4, 1'b0, 1'b1, 1'b0);
    expect_beat("bp_b3", 1, 3'd6, 1'b0, 1'b1, 1'b1);

    // round-robin: 1000_0001 three times -> 0, 7, 0; zero vector keeps ptr
    for (int i = 0; i < 3; i++) begin
      send(2, 8'h81);
      collect(2, 1);
      expect_beat("rr", 2, (i == 1) ? 3'd7 : 3'd0, 1'b0, 1'b1, 1'b1);
    end
    send(2, 8'h00);
    collect(2, 1);
    expect_beat("rr_zero", 2, 3'd0, 1'b1, 1'b0, 1'b1);
    send(2, 8'h81);
    collect(2, 1);
    expect_beat("rr_after_zero", 2, 3'd7, 1'b0, 1'b1, 1'b1);

    // N=5 round-robin drain: 10001 twice -> 0, 4, 0, 4
    for (int i = 0; i < 2; i++) begin
      send(3, 8'h11);
      collect(3, 2);
      expect_beat("n5_lo", 3, 3'd0, 1'b0, 1'b1, 1'b0);
      expect_beat("n5_hi", 3, 3'd4, 1'b0, 1'b1, 1'b1);
    end

    // reset in the middle of an 8'hFF drain
    send(1, 8'hFF);
    step();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 1, ov[1], 0);
    check("rst_mid_beat", 1, beat_of(1), 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    send(1, 8'h04);
    collect(1, 1);
    expect_beat("post_rst", 1, 3'd2, 1'b0, 1'b0, 1'b1);

    // randomized traffic on all configurations
    for (int t = 0; t < 1500; t++) begin
      for (int k = 0; k < NI; k++) begin
        vin[k]  = 1'($urandom_range(0, 1));
        ordy[k] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0:       req[k] = 8'h00;
          1:       req[k] = 8'(1 << $urandom_range(0, n_of(k) - 1));
          default: req[k] = 8'($urandom_range(0, 255));
        endcase
      end
      step();
      for (int k = 0; k < NI; k++) got_q[k].delete();
    end
    vin  = '0;
    ordy = '1;
    repeat (20) step();
    for (int k = 0; k < NI; k++) check("final_empty", k, exp_q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
